// File: rtl/player_motion_ctl_pkg.sv
// Shared types and constants for the player motion controller and the draw modules.
package player_motion_ctl_pkg;

    typedef enum logic [1:0] {
        MS_IDLE  = 2'd0,
        MS_LEFT  = 2'd1,
        MS_RIGHT = 2'd2
    } motion_state_t;

    localparam int X_MAX_DEF    = 760;
    localparam int BLOCK_LO_DEF = 350;
    localparam int BLOCK_HI_DEF = 450;

    // A single player still needs a 1-bit select so that sel=1 can mean "nobody".
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/player_motion_ctl_if.sv
// Input/output bundle of the motion controller: shared controls in, packed per-player state out.
interface player_motion_ctl_if #(
    parameter int N_PLAYERS = 2,
    parameter int POS_W     = 12
);
    import player_motion_ctl_pkg::*;

    localparam int SEL_W = sel_width(N_PLAYERS);

    // No handshake: v_tick is a level whose rising edge is a frame; all other inputs are
    // sampled on that edge and every output holds steady between frames.
    logic                       v_tick;
    logic [SEL_W-1:0]           sel;
    logic                       m_left;
    logic                       m_right;
    logic                       jump;
    logic                       gate_open;
    logic [N_PLAYERS*POS_W-1:0] xpos;
    logic [N_PLAYERS*POS_W-1:0] ypos;
    logic [N_PLAYERS*2-1:0]     mstate;
    logic [N_PLAYERS-1:0]       airborne;

    modport master (
        output v_tick, sel, m_left, m_right, jump, gate_open,
        input  xpos, ypos, mstate, airborne
    );

    modport slave (
        input  v_tick, sel, m_left, m_right, jump, gate_open,
        output xpos, ypos, mstate, airborne
    );

endinterface

// File: rtl/player_motion_unit.sv
// One player's horizontal motion FSM, gated-obstacle clamp and jump/gravity arc.
module player_motion_unit
    import player_motion_ctl_pkg::*;
#(
    parameter int POS_W    = 12,
    parameter int X_RESET  = 0,
    parameter int X_MAX    = X_MAX_DEF,
    parameter int BLOCK_LO = BLOCK_LO_DEF,
    parameter int BLOCK_HI = BLOCK_HI_DEF,
    parameter int STEP     = 1,
    parameter int Y_GROUND = 500,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             selected,
    input  logic             m_left,
    input  logic             m_right,
    input  logic             jump,
    input  logic             gate_open,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output motion_state_t    mstate,
    output logic             airborne
);

    localparam int VW = POS_W + 1;
    localparam logic [POS_W-1:0] X_RST_V = POS_W'(X_RESET);
    localparam logic [POS_W-1:0] X_MAX_V = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] LO_V    = POS_W'(BLOCK_LO);
    localparam logic [POS_W-1:0] HI_V    = POS_W'(BLOCK_HI);
    localparam logic [POS_W-1:0] LO_M1_V = POS_W'(BLOCK_LO - 1);
    localparam logic [POS_W-1:0] HI_P1_V = POS_W'(BLOCK_HI + 1);
    localparam logic [POS_W-1:0] STEP_V  = POS_W'(STEP);
    localparam logic [POS_W-1:0] YG_V    = POS_W'(Y_GROUND);
    localparam logic [POS_W-1:0] V0_H    = POS_W'(JUMP_V0);
    localparam logic signed [VW-1:0] V0_S   = VW'(JUMP_V0);
    localparam logic signed [VW-1:0] GRAV_S = VW'(GRAVITY);

    motion_state_t          state_q, state_d;
    logic [POS_W-1:0]       x_q, x_d, x_move;
    logic [POS_W:0]         x_inc;
    logic [POS_W-1:0]       h_q, h_d;
    logic signed [VW-1:0]   vy_q, vy_d;
    logic                   air_q, air_d;
    logic signed [POS_W+1:0] h_sum;

    function automatic logic in_block(input logic [POS_W-1:0] v);
        return (v >= LO_V) && (v <= HI_V);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MS_IDLE;
            x_q     <= X_RST_V;
            h_q     <= '0;
            vy_q    <= '0;
            air_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            h_q     <= h_d;
            vy_q    <= vy_d;
            air_q   <= air_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            if (selected && m_left && !m_right) begin
                state_d = MS_LEFT;
            end else if (selected && m_right && !m_left) begin
                state_d = MS_RIGHT;
            end else begin
                state_d = MS_IDLE;
            end
        end
    end

    always_comb begin
        mstate   = state_q;
        airborne = air_q;
        x        = x_q;
        y        = YG_V - h_q;
    end

    // The move is taken on the same frame the direction is decoded.
    always_comb begin
        x_inc  = {1'b0, x_q} + {1'b0, STEP_V};
        x_move = x_q;
        case (state_d)
            MS_LEFT:  x_move = (x_q < STEP_V) ? '0 : x_q - STEP_V;
            MS_RIGHT: x_move = (x_inc > {1'b0, X_MAX_V}) ? X_MAX_V : x_inc[POS_W-1:0];
            default:  x_move = x_q;
        endcase
        // Entry from outside is stopped at the wall; a player already inside roams freely.
        if (!gate_open && !in_block(x_q) && in_block(x_move)) begin
            x_move = (x_q < LO_V) ? LO_M1_V : HI_P1_V;
        end
        x_d = tick ? x_move : x_q;
    end

    always_comb begin
        h_d   = h_q;
        vy_d  = vy_q;
        air_d = air_q;
        h_sum = $signed({2'b00, h_q}) + $signed({vy_q[VW-1], vy_q});
        if (tick) begin
            if (air_q) begin
                if (h_sum[POS_W+1] || (h_sum == '0)) begin
                    h_d   = '0;
                    vy_d  = '0;
                    air_d = 1'b0;
                end else begin
                    h_d  = (h_sum[POS_W:0] > {1'b0, YG_V}) ? YG_V : h_sum[POS_W-1:0];
                    vy_d = vy_q - GRAV_S;
                end
            end else if (selected && jump) begin
                // The launch frame already climbs by the full initial velocity.
                air_d = 1'b1;
                h_d   = V0_H;
                vy_d  = V0_S - GRAV_S;
            end
        end
    end

endmodule

// File: rtl/player_motion_ctl.sv
// Frame-rate motion controller: frame-edge detect, player select decode and one unit per player.
module player_motion_ctl
    import player_motion_ctl_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int POS_W     = 12,
    parameter int X_MAX     = X_MAX_DEF,
    parameter int BLOCK_LO  = BLOCK_LO_DEF,
    parameter int BLOCK_HI  = BLOCK_HI_DEF,
    parameter int STEP      = 1,
    parameter int X_START   = 0,
    parameter int X_SPACING = 40,
    parameter int Y_GROUND  = 500,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1
) (
    input logic              clk,
    input logic              rst,
    player_motion_ctl_if.slave bus
);

    localparam int SEL_W = sel_width(N_PLAYERS);

    logic          v_tick_d_q, v_tick_d_d;
    logic          tick;
    logic [POS_W-1:0] x_arr   [N_PLAYERS];
    logic [POS_W-1:0] y_arr   [N_PLAYERS];
    motion_state_t    ms_arr  [N_PLAYERS];
    logic             air_arr [N_PLAYERS];

    // Resetting the delayed copy high suppresses a frame when v_tick is already high at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_tick_d_q <= 1'b1;
        end else begin
            v_tick_d_q <= v_tick_d_d;
        end
    end

    always_comb begin
        v_tick_d_d = bus.v_tick;
        tick       = bus.v_tick & ~v_tick_d_q;
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
        localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
        logic selected;
        assign selected = (bus.sel == IDX);

        player_motion_unit #(
            .POS_W    (POS_W),
            .X_RESET  (X_START + i * X_SPACING),
            .X_MAX    (X_MAX),
            .BLOCK_LO (BLOCK_LO),
            .BLOCK_HI (BLOCK_HI),
            .STEP     (STEP),
            .Y_GROUND (Y_GROUND),
            .JUMP_V0  (JUMP_V0),
            .GRAVITY  (GRAVITY)
        ) u_unit (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .selected  (selected),
            .m_left    (bus.m_left),
            .m_right   (bus.m_right),
            .jump      (bus.jump),
            .gate_open (bus.gate_open),
            .x         (x_arr[i]),
            .y         (y_arr[i]),
            .mstate    (ms_arr[i]),
            .airborne  (air_arr[i])
        );
    end

    always_comb begin
        bus.xpos     = '0;
        bus.ypos     = '0;
        bus.mstate   = '0;
        bus.airborne = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            bus.xpos[i*POS_W +: POS_W] = x_arr[i];
            bus.ypos[i*POS_W +: POS_W] = y_arr[i];
            bus.mstate[2*i +: 2]       = ms_arr[i];
            bus.airborne[i]            = air_arr[i];
        end
    end

endmodule

// File: tb/tb_player_motion_ctl.sv
// Directed bench for player_motion_ctl: two players, default geometry, hand-computed expectations.
module tb_player_motion_ctl;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    player_motion_ctl_if #(.N_PLAYERS(2), .POS_W(12)) bus ();

    player_motion_ctl #(.N_PLAYERS(2), .POS_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic frame();
        @(negedge clk);
        bus.v_tick = 1'b1;
        @(negedge clk);
        bus.v_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic drive(input logic s, input logic l, input logic r, input logic j, input logic g);
        bus.sel       = s;
        bus.m_left    = l;
        bus.m_right   = r;
        bus.jump      = j;
        bus.gate_open = g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.v_tick = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        bus.v_tick = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.xpos !== {12'd40, 12'd0} || bus.ypos !== {12'd500, 12'd500} ||
            bus.mstate !== 4'd0 || bus.airborne !== 2'b00) begin
            errors++;
            $display("FAIL reset_values x=%h y=%h ms=%h air=%b want x=028000 y=1f41f4 ms=0 air=00",
                     bus.xpos, bus.ypos, bus.mstate, bus.airborne);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.xpos[11:0] !== 12'd0) begin
            errors++;
            $display("FAIL no_tick_after_reset x0 got %0d want 0", bus.xpos[11:0]);
        end
        bus.v_tick = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(3);
        checks++;
        if (bus.xpos !== {12'd40, 12'd0} || bus.ypos !== {12'd500, 12'd500} ||
            bus.mstate !== 4'd0 || bus.airborne !== 2'b00) begin
            errors++;
            $display("FAIL idle_ticks x=%h y=%h ms=%h air=%b", bus.xpos, bus.ypos, bus.mstate, bus.airborne);
        end
    endtask

    task automatic test_gate_block();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        frames(340);
        checks++;
        if (bus.xpos[11:0] !== 12'd340) begin
            errors++;
            $display("FAIL walk_to_340 x0 got %0d want 340", bus.xpos[11:0]);
        end
        bus.gate_open = 1'b0;
        frames(20);
        checks++;
        if (bus.xpos[11:0] !== 12'd349 || bus.mstate[1:0] !== 2'd2) begin
            errors++;
            $display("FAIL gate_stop x0 got %0d ms0 %0d want 349 ms0 2", bus.xpos[11:0], bus.mstate[1:0]);
        end
        checks++;
        if (bus.xpos[23:12] !== 12'd40) begin
            errors++;
            $display("FAIL gate_stop_x1 x1 got %0d want 40", bus.xpos[23:12]);
        end
        bus.gate_open = 1'b1;
        frames(10);
        checks++;
        if (bus.xpos[11:0] !== 12'd359 || bus.xpos[23:12] !== 12'd40) begin
            errors++;
            $display("FAIL gate_open_pass x0 got %0d x1 got %0d want 359 40", bus.xpos[11:0], bus.xpos[23:12]);
        end
    endtask

    task automatic test_left_clamp();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frames(20);
        checks++;
        if (bus.xpos[23:12] !== 12'd20) begin
            errors++;
            $display("FAIL left_walk x1 got %0d want 20", bus.xpos[23:12]);
        end
        frames(30);
        checks++;
        if (bus.xpos[23:12] !== 12'd0 || bus.mstate[3:2] !== 2'd1) begin
            errors++;
            $display("FAIL left_clamp x1 got %0d ms1 %0d want 0 ms1 1", bus.xpos[23:12], bus.mstate[3:2]);
        end
        checks++;
        if (bus.xpos[11:0] !== 12'd359 || bus.mstate[1:0] !== 2'd0) begin
            errors++;
            $display("FAIL unselected_hold x0 got %0d ms0 %0d want 359 ms0 0", bus.xpos[11:0], bus.mstate[1:0]);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(3);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        frames(2);
        checks++;
        if (bus.xpos[23:12] !== 12'd3 || bus.mstate[3:2] !== 2'd0) begin
            errors++;
            $display("FAIL both_dirs x1 got %0d ms1 %0d want 3 ms1 0", bus.xpos[23:12], bus.mstate[3:2]);
        end
    endtask

    task automatic test_jump();
        int exp_y [25] = '{488, 477, 467, 458, 450, 443, 437, 432, 428, 425, 423, 422, 422,
                           423, 425, 428, 432, 437, 443, 450, 458, 467, 477, 488, 500};
        for (int k = 1; k <= 25; k++) begin
            if (k <= 5) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            else        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            frame();
            checks++;
            if (bus.ypos[11:0] !== 12'(exp_y[k-1]) || bus.airborne[0] !== (k < 25)) begin
                errors++;
                $display("FAIL jump_arc tick %0d y0 got %0d air0 %b want %0d air0 %b",
                         k, bus.ypos[11:0], bus.airborne[0], exp_y[k-1], (k < 25));
            end
        end
        checks++;
        if (bus.ypos[23:12] !== 12'd500 || bus.airborne[1] !== 1'b0) begin
            errors++;
            $display("FAIL jump_other y1 got %0d air1 %b want 500 0", bus.ypos[23:12], bus.airborne[1]);
        end
    endtask

    task automatic test_held_tick_and_reset();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        bus.v_tick = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (bus.xpos[11:0] !== 12'd1) begin
            errors++;
            $display("FAIL held_tick x0 got %0d want 1", bus.xpos[11:0]);
        end
        bus.v_tick = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        frame();
        bus.jump = 1'b0;
        frames(2);
        checks++;
        if (bus.ypos[11:0] !== 12'd467 || bus.airborne[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_jump y0 got %0d air0 %b want 467 1", bus.ypos[11:0], bus.airborne[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ypos[11:0] !== 12'd500 || bus.airborne[0] !== 1'b0 || bus.xpos[11:0] !== 12'd0) begin
            errors++;
            $display("FAIL reset_abort y0 got %0d air0 %b x0 %0d want 500 0 0",
                     bus.ypos[11:0], bus.airborne[0], bus.xpos[11:0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_inside_block();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        frames(400);
        checks++;
        if (bus.xpos[11:0] !== 12'd400) begin
            errors++;
            $display("FAIL walk_to_400 x0 got %0d want 400", bus.xpos[11:0]);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frame();
        checks++;
        if (bus.xpos[11:0] !== 12'd399) begin
            errors++;
            $display("FAIL inside_left x0 got %0d want 399", bus.xpos[11:0]);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        frame();
        bus.gate_open = 1'b0;
        frame();
        checks++;
        if (bus.xpos[11:0] !== 12'd401) begin
            errors++;
            $display("FAIL inside_right x0 got %0d want 401", bus.xpos[11:0]);
        end
        bus.gate_open = 1'b1;
        frames(59);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frames(20);
        checks++;
        if (bus.xpos[11:0] !== 12'd451) begin
            errors++;
            $display("FAIL right_wall x0 got %0d want 451", bus.xpos[11:0]);
        end
    endtask

    task automatic test_right_clamp();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        frames(720);
        checks++;
        if (bus.xpos[23:12] !== 12'd760) begin
            errors++;
            $display("FAIL reach_xmax x1 got %0d want 760", bus.xpos[23:12]);
        end
        frames(5);
        checks++;
        if (bus.xpos[23:12] !== 12'd760 || bus.mstate[3:2] !== 2'd2) begin
            errors++;
            $display("FAIL xmax_clamp x1 got %0d ms1 %0d want 760 ms1 2", bus.xpos[23:12], bus.mstate[3:2]);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.v_tick = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_gate_block();
        test_left_clamp();
        test_jump();
        test_held_tick_and_reset();
        test_inside_block();
        test_right_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
